// File: rtl/led_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// led_frame_buffer_if
//
// Bundles the writer, reader and status signals of led_frame_buffer.
//
// Handshake semantics:
//   - Write side: the writer drives i_wr_en/i_wr_addr/i_wr_data and is allowed to
//     write while o_wr_ready is high. A write presented while o_wr_ready is low
//     is not stalled; it is dropped and latches o_wr_overrun. i_wr_frame_done is a
//     single-cycle pulse that hands the back bank over for a swap. o_wr_ready
//     stays low until that swap has been performed.
//   - Read side: i_rd_en/i_rd_addr form a request that is always accepted.
//     o_rd_valid qualifies o_rd_data and follows i_rd_en after the fixed read
//     latency. i_rd_busy held high by the reader blocks the bank swap.
//   - Status: o_frame_valid pulses once per swap. o_frame_cnt counts swaps.
//
// Modports:
//   master : pattern generator + serializer side (drives the i_* signals)
//   slave  : the frame buffer itself (drives the o_* signals)
// -----------------------------------------------------------------------------
interface led_frame_buffer_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_W      = 8,
  parameter int FRAME_CNT_W = 8
);

  // writer
  logic                   i_wr_en;
  logic [ADDR_WIDTH-1:0]  i_wr_addr;
  logic [DATA_W-1:0]      i_wr_data;
  logic                   i_wr_frame_done;
  logic                   o_wr_ready;

  // reader
  logic                   i_rd_en;
  logic [ADDR_WIDTH-1:0]  i_rd_addr;
  logic [DATA_W-1:0]      o_rd_data;
  logic                   o_rd_valid;
  logic                   i_rd_busy;

  // status
  logic                   o_frame_valid;
  logic [FRAME_CNT_W-1:0] o_frame_cnt;
  logic                   o_wr_overrun;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_frame_done,
    output i_rd_en, i_rd_addr, i_rd_busy,
    input  o_wr_ready, o_rd_data, o_rd_valid,
    input  o_frame_valid, o_frame_cnt, o_wr_overrun
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_frame_done,
    input  i_rd_en, i_rd_addr, i_rd_busy,
    output o_wr_ready, o_rd_data, o_rd_valid,
    output o_frame_valid, o_frame_cnt, o_wr_overrun
  );

endinterface

// File: rtl/led_frame_buffer.sv
// -----------------------------------------------------------------------------
// led_frame_buffer
//
// Ping-pong frame store between the LED pattern generator (writer) and the SPI
// LED serializer (reader). The writer fills the back bank, then pulses
// i_wr_frame_done. The swap is deferred until the reader reports idle
// (i_rd_busy low), so a frame is never torn mid-transmission.
//
// Bank roles follow sel: sel=0 -> write A / read B, sel=1 -> write B / read A.
//
// Ports:
//   i_clk         single clock
//   i_rst_n       synchronous, active-low reset
//   bus (slave)   writer / reader / status signals, see led_frame_buffer_if
//   i_brightness  global scale, 0..255 (only with LED_FB_BRIGHTNESS_EN)
//   o_dbg_state   current FSM state (0 = FILL, 1 = PEND)
//
// Build option:
//   LED_FB_BRIGHTNESS_EN  adds i_brightness and a second output register stage
//                         computing (raw * (i_brightness+1)) >> 8. Read latency
//                         becomes 2. Undefined: no scaling, read latency 1.
// -----------------------------------------------------------------------------
module led_frame_buffer #(
  parameter int LEDS          = 30,
  parameter int BYTES_PER_LED = 3,
  parameter int DATA_W        = 8,
  parameter int DEPTH         = LEDS * BYTES_PER_LED,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int FRAME_CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
`ifdef LED_FB_BRIGHTNESS_EN
  input  logic [7:0]         i_brightness,
`endif
  led_frame_buffer_if.slave  bus,
  output logic               o_dbg_state
);

  // One extra bit so DEPTH itself is representable even when it is a power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                   sel_q;
  logic                   front_loaded_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   frame_valid_q;
  logic                   overrun_q;

  logic                   wr_commit;
  logic                   swap;
  logic                   overrun_set;
  logic                   wr_in_range;
  logic                   rd_in_range;

  logic [DATA_W-1:0]      bank_a [DEPTH];
  logic [DATA_W-1:0]      bank_b [DEPTH];
  logic [DATA_W-1:0]      front_word;

  logic [DATA_W-1:0]      raw_q;
  logic                   raw_valid_q;

  assign wr_in_range = ({1'b0, bus.i_wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, bus.i_rd_addr} < DEPTH_W);

  // ---------------------------------------------------------------------------
  // Swap FSM: next state and per-cycle actions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_commit   = 1'b0;
    swap        = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      FILL: begin
        // A write in the same cycle as frame_done still lands in the back bank.
        wr_commit = bus.i_wr_en && wr_in_range;
        if (bus.i_wr_frame_done) begin
          state_d = PEND;
        end
      end
      PEND: begin
        // The back bank is frozen while a swap is pending; any further writer
        // activity means the generator is running ahead of the serializer.
        overrun_set = bus.i_wr_en || bus.i_wr_frame_done;
        if (!bus.i_rd_busy) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= FILL;
      sel_q          <= 1'b0;
      front_loaded_q <= 1'b0;
      frame_cnt_q    <= '0;
      frame_valid_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_valid_q <= swap;
      if (swap) begin
        sel_q          <= ~sel_q;
        frame_cnt_q    <= frame_cnt_q + 1'b1;
        front_loaded_q <= 1'b1;
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (wr_commit && i_rst_n) begin
      if (!sel_q) begin
        bank_a[bus.i_wr_addr] <= bus.i_wr_data;
      end else begin
        bank_b[bus.i_wr_addr] <= bus.i_wr_data;
      end
    end
  end

  // Front bank is the one not being written; sel_q is the pre-edge value, so a
  // read issued on the swap edge still sees the outgoing frame.
  always_comb begin
    front_word = '0;
    if (rd_in_range) begin
      front_word = sel_q ? bank_a[bus.i_rd_addr] : bank_b[bus.i_rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: registered raw word
  // ---------------------------------------------------------------------------
`ifdef LED_FB_BRIGHTNESS_EN
  logic [7:0] bright_q;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
`ifdef LED_FB_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      raw_valid_q <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        // Unloaded front bank or out-of-range address reads as zero.
        raw_q <= (front_loaded_q && rd_in_range) ? front_word : '0;
`ifdef LED_FB_BRIGHTNESS_EN
        bright_q <= i_brightness;
`endif
      end
    end
  end

`ifdef LED_FB_BRIGHTNESS_EN
  // ---------------------------------------------------------------------------
  // Read stage 2: brightness scaling. Scale factor is brightness+1 (1..256) so
  // that 255 is an exact pass-through after the >>8.
  // ---------------------------------------------------------------------------
  logic [8:0]          scale;
  logic [DATA_W+8:0]   product;
  logic [DATA_W-1:0]   scaled_q;
  logic                scaled_valid_q;

  assign scale   = {1'b0, bright_q} + 9'd1;
  assign product = {9'd0, raw_q} * {{DATA_W{1'b0}}, scale};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scaled_q       <= '0;
      scaled_valid_q <= 1'b0;
    end else begin
      scaled_valid_q <= raw_valid_q;
      if (raw_valid_q) begin
        scaled_q <= product[DATA_W+7:8];
      end
    end
  end

  assign bus.o_rd_data  = scaled_q;
  assign bus.o_rd_valid = scaled_valid_q;
`else
  assign bus.o_rd_data  = raw_q;
  assign bus.o_rd_valid = raw_valid_q;
`endif

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign bus.o_wr_ready    = (state_q == FILL);
  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_frame_cnt   = frame_cnt_q;
  assign bus.o_wr_overrun  = overrun_q;
  assign o_dbg_state       = state_q;

endmodule
